// File: rtl/weight_s_loader_mmap_m_axi_srl_fifo_if.sv
// Push/pop handshake bundle for the loader m_axi SRL FIFO.
// The master drives requests and data; the slave (the FIFO) returns status and the head word.
interface weight_s_loader_mmap_m_axi_srl_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   occupancy;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, almost_full, occupancy
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, almost_full, occupancy
    );
endinterface

// File: rtl/weight_s_loader_mmap_m_axi_srl_fifo.sv
// SRL-based FIFO with a registered output stage, registered flags and occupancy.
// Storage is DEPTH-1 words of shift register plus the output register; no bypass path.
module weight_s_loader_mmap_m_axi_srl_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DEPTH       = 63,
    parameter int unsigned AFULL_LEVEL = 56
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    weight_s_loader_mmap_m_axi_srl_fifo_if.slave fifo
);
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned SRL_DEPTH = (DEPTH > 1) ? DEPTH - 1 : 1;
    localparam bit          HAS_SRL   = (DEPTH > 1);

    logic [DATA_WIDTH-1:0] mem_q [SRL_DEPTH];

    logic [CNT_W-1:0]      srl_cnt_q, srl_cnt_d;
    logic [CNT_W-1:0]      occupancy_q, occupancy_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_q, afull_d;

    logic                  push, pop, load;
    logic [ADDR_WIDTH-1:0] raddr;

    // Next-state: output register reads the pre-shift oldest SRL word.
    always_comb begin
        push        = clk_en & fifo.if_write & full_n_q;
        pop         = clk_en & fifo.if_read & empty_n_q;
        raddr       = ADDR_WIDTH'(srl_cnt_q - CNT_W'(1));
        load        = 1'b0;
        dout_d      = dout_q;
        srl_cnt_d   = srl_cnt_q;
        if (HAS_SRL) begin
            load      = clk_en & (srl_cnt_q != '0) & (~empty_n_q | pop);
            srl_cnt_d = srl_cnt_q + CNT_W'(push) - CNT_W'(load);
            if (load) begin
                dout_d = mem_q[raddr];
            end
        end else begin
            // Single-entry case: the output register is the only storage.
            load      = push;
            srl_cnt_d = '0;
            if (load) begin
                dout_d = fifo.if_din;
            end
        end
        empty_n_d   = load | (empty_n_q & ~pop);
        occupancy_d = srl_cnt_d + CNT_W'(empty_n_d);
        full_n_d    = (occupancy_d < CNT_W'(DEPTH));
        afull_d     = (occupancy_d >= CNT_W'(AFULL_LEVEL));
    end

    // Shift storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[0] <= fifo.if_din;
            for (int i = 1; i < int'(SRL_DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            srl_cnt_q   <= '0;
            occupancy_q <= '0;
            dout_q      <= '0;
            empty_n_q   <= 1'b0;
            full_n_q    <= 1'b1;
            afull_q     <= 1'b0;
        end else begin
            srl_cnt_q   <= srl_cnt_d;
            occupancy_q <= occupancy_d;
            dout_q      <= dout_d;
            empty_n_q   <= empty_n_d;
            full_n_q    <= full_n_d;
            afull_q     <= afull_d;
        end
    end

    assign fifo.if_dout     = dout_q;
    assign fifo.if_empty_n  = empty_n_q;
    assign fifo.if_full_n   = full_n_q;
    assign fifo.almost_full = afull_q;
    assign fifo.occupancy   = occupancy_q;
endmodule

// File: tb/tb_weight_s_loader_mmap_m_axi_srl_fifo.sv
// Directed bench for the loader SRL FIFO: hand-computed checks plus a word-level queue model.
module tb_weight_s_loader_mmap_m_axi_srl_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 63;
    localparam int unsigned AFULL = 56;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    weight_s_loader_mmap_m_axi_srl_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    weight_s_loader_mmap_m_axi_srl_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(AFULL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clk_en(clk_en),
        .fifo  (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference: words not yet in the output register, plus the output register itself.
    logic [DW-1:0] srlq[$];
    logic          m_outv;
    logic [DW-1:0] m_outd;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_occ();
        return srlq.size() + int'(m_outv);
    endfunction

    task automatic check_model();
        check("dout",     bus.if_dout, m_outd);
        check("empty_n",  DW'(bus.if_empty_n), DW'(m_outv));
        check("occ",      DW'(bus.occupancy), DW'(m_occ()));
        check("full_n",   DW'(bus.if_full_n), DW'(m_occ() < int'(DEPTH)));
        check("afull",    DW'(bus.almost_full), DW'(m_occ() >= int'(AFULL)));
    endtask

    task automatic step(input logic en, input logic wr, input logic [DW-1:0] d, input logic rd);
        logic m_push, m_pop, m_load;
        clk_en       = en;
        bus.if_write = wr;
        bus.if_din   = d;
        bus.if_read  = rd;
        m_push = en && wr && (m_occ() < int'(DEPTH));
        m_pop  = en && rd && m_outv;
        m_load = en && (srlq.size() > 0) && (!m_outv || m_pop);
        @(posedge clk); #1;
        if (m_load) m_outd = srlq.pop_front();
        if (m_push) srlq.push_back(d);
        m_outv = m_load || (m_outv && !m_pop);
        check_model();
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        reset        = 1'b1;
        clk_en       = 1'b1;
        bus.if_write = wr;
        bus.if_read  = rd;
        bus.if_din   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset = 1'b0;
        srlq.delete();
        m_outv = 1'b0;
        m_outd = '0;
        check("rst_empty_n", DW'(bus.if_empty_n), 32'd0);
        check("rst_full_n",  DW'(bus.if_full_n),  32'd1);
        check("rst_occ",     DW'(bus.occupancy),  32'd0);
        check("rst_dout",    bus.if_dout,         32'd0);
        check("rst_afull",   DW'(bus.almost_full), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] prev_dout;
        reset        = 1'b1;
        clk_en       = 1'b0;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        bus.if_din   = '0;
        srlq.delete();
        m_outv = 1'b0;
        m_outd = '0;

        // 1: reset then idle
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            check("idle_empty_n", DW'(bus.if_empty_n), 32'd0);
            check("idle_dout",    bus.if_dout,         32'd0);
        end

        // 2: single push, one-cycle latency, then pop
        step(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        check("lat_empty_n_T", DW'(bus.if_empty_n), 32'd0);
        check("lat_occ_T",     DW'(bus.occupancy),  32'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("lat_empty_n_T1", DW'(bus.if_empty_n), 32'd1);
        check("lat_dout_T1",    bus.if_dout,          32'hA5A5_0001);
        step(1'b1, 1'b0, '0, 1'b1);
        check("pop_occ",     DW'(bus.occupancy),  32'd0);
        check("pop_empty_n", DW'(bus.if_empty_n), 32'd0);
        step(1'b1, 1'b0, '0, 1'b1);   // pop from empty is ignored
        check("pop_empty_occ", DW'(bus.occupancy), 32'd0);

        // 3: fill to DEPTH, overflow push ignored, drain in order
        for (int k = 0; k < int'(DEPTH); k++) begin
            step(1'b1, 1'b1, DW'(k), 1'b0);
            check("fill_occ",   DW'(bus.occupancy),   DW'(k + 1));
            check("fill_afull", DW'(bus.almost_full), DW'((k + 1) >= 56));
        end
        check("full_full_n", DW'(bus.if_full_n), 32'd0);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("overflow_occ", DW'(bus.occupancy), 32'd63);
        // full with push and pop together: push rejected, full_n back next cycle
        check("full_head", bus.if_dout, 32'd0);
        step(1'b1, 1'b1, 32'h0BAD_0BAD, 1'b1);
        check("fullpp_occ",    DW'(bus.occupancy), 32'd62);
        check("fullpp_full_n", DW'(bus.if_full_n), 32'd1);
        for (int k = 1; k < int'(DEPTH); k++) begin
            check("drain_order", bus.if_dout, DW'(k));
            step(1'b1, 1'b0, '0, 1'b1);
        end
        check("drain_occ", DW'(bus.occupancy), 32'd0);

        // 4: steady push+pop at occupancy 10
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 32'h1000_0000 + DW'(k), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 200; k++) begin
            prev_dout = bus.if_dout;
            check("stream_seq", prev_dout, 32'h1000_0000 + DW'(k));
            step(1'b1, 1'b1, 32'h1000_000A + DW'(k), 1'b1);
            check("stream_occ",     DW'(bus.occupancy),  32'd10);
            check("stream_empty_n", DW'(bus.if_empty_n), 32'd1);
        end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, '0, 1'b1);

        // 5: random clk_en with mixed traffic
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 2) == 0));
        end
        for (int k = 0; k < 80; k++) step(1'b1, 1'b0, '0, 1'b1);

        // 6: reset at occupancy 30 with push and pop high
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 32'h3000_0000 + DW'(k), 1'b0);
        check("pre_rst_occ", DW'(bus.occupancy), 32'd30);
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h6000_0000 + DW'(k), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_data", bus.if_dout, 32'h6000_0000 + DW'(k));
            step(1'b1, 1'b0, '0, 1'b1);
        end
        check("post_rst_empty", DW'(bus.if_empty_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
